rs_syndrome_calc: RTL and testbench
===================================

Name: rs_syndrome_calc

Overview:
- Serial RS(255,k) syndrome generator over GF(256), primitive polynomial 0x11D.
- Sits directly upstream of the Berlekamp-Massey stage.
- Accepts received codeword bytes one per valid cycle and evaluates S_j = r(alpha^(FCR+j)) for j = 0..NSYM-1 by Horner's rule.
- Streams the NSYM syndromes out serially on data/valid/length signals that connect directly to the BM input (data_in, valid_in, syndome_len).

Parameters:
- NSYM, 16, number of syndromes (2t); must equal BM MAX_LENGTH; range 2..32.
- FCR, 0, first consecutive root exponent; syndrome j uses alpha^(FCR+j).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  start pulse; latches cw_len when IDLE.
- cw_len  input  8  codeword length in bytes, 1..255; 0 illegal.
- data_in  input  8  received byte, highest-degree coefficient first.
- valid_in  input  1  data_in qualifier.
- synd_out  output  8  syndrome value S_j.
- synd_len  output  8  constant NSYM; wired to BM syndome_len.
- valid_out  output  1  synd_out qualifier.
- last_out  output  1  high with S_(NSYM-1).
- no_error  output  1  all syndromes zero; valid only while valid_out or no_error pulse.
- busy  output  1  high in ACCUM and OUTPUT.

Behaviour:
- Reset values: synd_out=0, valid_out=0, last_out=0, no_error=0, busy=0, state=IDLE, all S_j=0, byte counter=0. synd_len is constant NSYM at all times.
- States: IDLE, ACCUM, OUTPUT.
- IDLE:
  - enable=1 -> clear all S_j, clear counter, latch cw_len, go to ACCUM.
  - If cw_len=0 -> go directly to OUTPUT with all syndromes zero.
  - valid_in is ignored in IDLE.
- ACCUM:
  - Each cycle with valid_in=1: for every j, S_j <= gfmul(S_j, alpha^(FCR+j)) XOR data_in; counter increments.
  - Constant multipliers are generated at elaboration time.
  - Cycles with valid_in=0 hold all state; gaps are unlimited.
  - On the accepted byte where counter == latched_len-1 -> go to OUTPUT.
- OUTPUT:
  - First valid_out occurs in the cycle after the last byte is accepted.
  - Emits S_0..S_(NSYM-1) on NSYM consecutive cycles, no backpressure.
  - last_out is high on the final cycle.
  - no_error = (all S_j == 0), computed once on OUTPUT entry and held constant for the whole burst.
  - Returns to IDLE after the last cycle; busy drops in the same cycle valid_out drops.
- enable while busy: ignored; does not restart or relatch.
- enable on the same cycle busy falls: not accepted; accepted from the first IDLE cycle onward.
- valid_in during OUTPUT: ignored; upstream must not send the next codeword until busy=0.
- rst_n asserted mid-operation: immediate return to reset values; partial codeword discarded; no valid_out.
- GF multiply: shift-and-reduce with 0x11D. GF add: XOR.
- Counter is 8 bits; no wrap possible since cw_len <= 255.

Optional Feature:
- Macro: RS_SYND_ZERO_SKIP_EN.
- Defined: if all syndromes are zero on OUTPUT entry, the syndrome burst is suppressed.
  - valid_out stays 0.
  - no_error pulses high for exactly one cycle.
  - The block returns to IDLE the next cycle, so BM is never started for clean codewords.
- Not defined: the full NSYM-cycle burst is always emitted; no_error is high throughout the burst when syndromes are zero.

Test Plan:
- enable, cw_len=20, 20 bytes of 0x00 -> 16 valid_out cycles, all synd_out=0x00, no_error=1, last_out on 16th. With macro: one-cycle no_error pulse, no valid_out.
- cw_len=1, data 0x05 -> all 16 syndromes = 0x05, no_error=0, first valid_out one cycle after the byte is accepted.
- cw_len=2, data {0x01,0x00}, FCR=0 -> S_0..S_15 = 01,02,04,08,10,20,40,80,1D,3A,74,E8,CD,87,13,26.
- Same stimulus as the previous case with random valid_in gaps of 0-5 cycles -> identical syndromes and identical OUTPUT timing relative to the last byte.
- enable pulsed again during ACCUM and during OUTPUT with a different cw_len -> ignored; results match the original cw_len.
- rst_n low after 7 of 20 bytes, then a fresh enable with cw_len=2, data {0x01,0x00} -> no stale output; syndromes match the cw_len=2 case.

Source files
------------

// File: rtl/rs_syndrome_calc.sv
// Serial RS(255,k) syndrome generator over GF(256) (poly 0x11D), Horner evaluation per byte.
// Optional build macro RS_SYND_ZERO_SKIP_EN suppresses the burst for all-zero syndromes.
module rs_syndrome_calc #(
  parameter int NSYM = 16,
  parameter int FCR  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] cw_len,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic [7:0] synd_out,
  output logic [7:0] synd_len,
  output logic       valid_out,
  output logic       last_out,
  output logic       no_error,
  output logic       busy
);

  localparam int IDXW = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSYM - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCUM  = 2'd1;
  localparam logic [1:0] ST_OUTPUT = 2'd2;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_alpha_pow(input int e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < (e % 255); i++) r = gf_mul(r, 8'h02);
    return r;
  endfunction

  logic [1:0]      state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      len_q, len_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [7:0]      synd_q    [NSYM];
  logic [7:0]      synd_d    [NSYM];
  logic [7:0]      synd_step [NSYM];
  logic            all_zero;
  logic            out_st;

  // Each lane multiplies by a fixed root, so gf_mul collapses to an XOR network.
  genvar gi;
  generate
    for (gi = 0; gi < NSYM; gi++) begin : g_lane
      localparam logic [7:0] ROOT = gf_alpha_pow(FCR + gi);
      assign synd_step[gi] = gf_mul(synd_q[gi], ROOT) ^ data_in;
    end
  endgenerate

  always_comb begin
    all_zero = 1'b1;
    for (int i = 0; i < NSYM; i++) begin
      if (synd_q[i] != 8'h00) all_zero = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    idx_d   = idx_q;
    for (int i = 0; i < NSYM; i++) synd_d[i] = synd_q[i];
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          for (int i = 0; i < NSYM; i++) synd_d[i] = 8'h00;
          cnt_d   = 8'd0;
          len_d   = cw_len;
          idx_d   = '0;
          state_d = (cw_len == 8'd0) ? ST_OUTPUT : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (valid_in) begin
          for (int i = 0; i < NSYM; i++) synd_d[i] = synd_step[i];
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q - 8'd1) state_d = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
`ifdef RS_SYND_ZERO_SKIP_EN
        if (all_zero) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      len_q   <= 8'd0;
      idx_q   <= '0;
      for (int i = 0; i < NSYM; i++) synd_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      for (int i = 0; i < NSYM; i++) synd_q[i] <= synd_d[i];
    end
  end

  // Syndromes are frozen during OUTPUT, so all_zero is stable across the burst.
  assign out_st   = (state_q == ST_OUTPUT);
  assign busy     = (state_q != ST_IDLE);
  assign synd_len = 8'(NSYM);
  assign no_error = out_st & all_zero;
`ifdef RS_SYND_ZERO_SKIP_EN
  assign valid_out = out_st & ~all_zero;
`else
  assign valid_out = out_st;
`endif
  assign last_out = valid_out & (idx_q == LAST_IDX);
  assign synd_out = valid_out ? synd_q[idx_q] : 8'h00;

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Scoreboard bench for rs_syndrome_calc: expected syndromes queued at stimulus time, popped on valid_out.
// Honours RS_SYND_ZERO_SKIP_EN for the all-zero expectations.
module tb_rs_syndrome_calc;
  localparam int NSYM = 16;
  localparam int FCR  = 0;

  logic       clk, rst_n, enable, valid_in;
  logic [7:0] cw_len, data_in;
  logic [7:0] synd_out, synd_len;
  logic       valid_out, last_out, no_error, busy;

  rs_syndrome_calc #(.NSYM(NSYM), .FCR(FCR)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cw_len(cw_len),
    .data_in(data_in), .valid_in(valid_in), .synd_out(synd_out),
    .synd_len(synd_len), .valid_out(valid_out), .last_out(last_out),
    .no_error(no_error), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] s;
    logic       last;
    logic       ne;
  } exp_t;

  exp_t       sb_q[$];
  int         total = 0;
  int         bad   = 0;
  logic [7:0] cw      [256];
  logic [7:0] exp_tbl [255];
  logic [7:0] ref_tbl [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    while (y != 8'h00) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // Direct power-sum evaluation: S_j = sum r_i * alpha^((FCR+j)*(len-1-i)).
  function automatic logic [7:0] model_synd(input int len, input int j);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < len; i++)
      s = s ^ tb_mul(cw[i], exp_tbl[((FCR + j) * (len - 1 - i)) % 255]);
    return s;
  endfunction

  always @(negedge clk) begin
    if (rst_n && valid_out) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_vout", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("synd", synd_out, e.s);
        chk("last", last_out, e.last);
        chk("noerr", no_error, e.ne);
      end
    end
  end

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < NSYM + 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_idle"}, busy, 1'b0);
    chk({tag, "_noerr_low"}, no_error, 1'b0);
    chk({tag, "_sb_empty"}, sb_q.size(), 0);
  endtask

  task automatic run_cw(input string tag, input int len, input int maxgap,
                        input bit noisy, input bit use_tbl);
    logic [7:0] sv [NSYM];
    bit zero;
    zero = 1'b1;
    for (int j = 0; j < NSYM; j++) begin
      sv[j] = use_tbl ? ref_tbl[j] : model_synd(len, j);
      if (sv[j] != 8'h00) zero = 1'b0;
    end
`ifdef RS_SYND_ZERO_SKIP_EN
    if (!zero)
`endif
      for (int j = 0; j < NSYM; j++) sb_q.push_back('{s: sv[j], last: (j == NSYM - 1), ne: zero});
    $display("cw %s len=%0d gap<=%0d noisy=%0d zero=%0d", tag, len, maxgap, noisy, zero);

    enable = 1'b1; cw_len = 8'(len);
    @(posedge clk); #1;
    enable = 1'b0;
    for (int i = 0; i < len; i++) begin
      repeat ($urandom_range(maxgap, 0)) begin @(posedge clk); #1; end
      if (noisy && i == 3) begin
        enable = 1'b1; cw_len = 8'(len + 5);
        @(posedge clk); #1;
        enable = 1'b0; cw_len = 8'(len);
      end
      if (i == len - 1) chk({tag, "_pre_vout"}, valid_out, 1'b0);
      valid_in = 1'b1; data_in = cw[i];
      @(posedge clk); #1;
      valid_in = 1'b0;
    end
    chk({tag, "_busy"}, busy, 1'b1);
`ifdef RS_SYND_ZERO_SKIP_EN
    if (zero) begin
      chk({tag, "_skip_noerr"}, no_error, 1'b1);
      chk({tag, "_skip_vout"}, valid_out, 1'b0);
    end else
`endif
      chk({tag, "_first_vout"}, valid_out, 1'b1);
    if (noisy) begin
      enable = 1'b1; cw_len = 8'd3;
      @(posedge clk); #1;
      valid_in = 1'b1; data_in = 8'hAA;
      @(posedge clk); #1;
      enable = 1'b0; valid_in = 1'b0;
    end
    wait_idle(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    logic [7:0] tv [16];
    tv = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
           8'h1D, 8'h3A, 8'h74, 8'hE8, 8'hCD, 8'h87, 8'h13, 8'h26};
    for (int i = 0; i < 16; i++) ref_tbl[i] = tv[i];
    r = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_tbl[i] = r;
      r = tb_mul(r, 8'h02);
    end

    rst_n = 1'b0; enable = 1'b0; valid_in = 1'b0; cw_len = 8'd0; data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_synd", synd_out, 8'h00);
    chk("rst_vout", valid_out, 1'b0);
    chk("rst_last", last_out, 1'b0);
    chk("rst_noerr", no_error, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_len", synd_len, 8'd16);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", busy, 1'b0);

    for (int i = 0; i < 20; i++) cw[i] = 8'h00;
    run_cw("zeros20", 20, 0, 1'b0, 1'b0);

    cw[0] = 8'h05;
    run_cw("one_byte", 1, 0, 1'b0, 1'b0);

    cw[0] = 8'h01; cw[1] = 8'h00;
    run_cw("x_poly", 2, 0, 1'b0, 1'b1);
    run_cw("x_poly_gaps", 2, 5, 1'b0, 1'b1);

    for (int i = 0; i < 10; i++) cw[i] = 8'($urandom_range(255, 1));
    run_cw("noisy_en", 10, 1, 1'b1, 1'b0);

    // Abort a codeword part-way with reset; nothing from it may appear.
    $display("cw reset_abort len=20 after 7 bytes");
    enable = 1'b1; cw_len = 8'd20;
    @(posedge clk); #1;
    enable = 1'b0;
    for (int i = 0; i < 7; i++) begin
      valid_in = 1'b1; data_in = 8'($urandom_range(255, 0));
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    chk("abort_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_vout", valid_out, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_idle_vout", valid_out, 1'b0);
    cw[0] = 8'h01; cw[1] = 8'h00;
    run_cw("after_rst", 2, 0, 1'b0, 1'b1);

    run_cw("len0", 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 255; i++) cw[i] = 8'($urandom_range(255, 0));
    run_cw("len255", 255, 0, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) cw[i] = 8'($urandom_range(255, 0));
    run_cw("rand30", 30, 2, 1'b0, 1'b0);

    chk("synd_len_end", synd_len, 8'd16);
    chk("sb_final", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
